// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction field layout and fetch FSM states.
package if_pkg;

    localparam logic [1:0] FMT_JUMP = 2'b11;

    localparam int FMT_HI  = 15;
    localparam int FMT_LO  = 14;
    localparam int OPC_HI  = 13;
    localparam int OPC_LO  = 10;
    localparam int RD_HI   = 9;
    localparam int RD_LO   = 7;
    localparam int R1_HI   = 6;
    localparam int R1_LO   = 4;
    localparam int R2_HI   = 3;
    localparam int R2_LO   = 1;
    localparam int IMMF_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [1:0] format;
        logic [3:0] opcode;
        logic [2:0] reg_d;
        logic [2:0] reg1;
        logic [2:0] reg2;
        logic       imm_flag;
    } insn_fields_t;

    function automatic insn_fields_t split_word(input logic [15:0] w);
        insn_fields_t f;
        f.format   = w[FMT_HI:FMT_LO];
        f.opcode   = w[OPC_HI:OPC_LO];
        f.reg_d    = w[RD_HI:RD_LO];
        f.reg1     = w[R1_HI:R1_LO];
        f.reg2     = w[R2_HI:R2_LO];
        f.imm_flag = w[IMMF_BIT];
        return f;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO of 16-bit instruction words; supports popping one or two words per cycle and a full flush.
module if_prefetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [15:0]              data_i,
    input  logic                     pop1_i,
    input  logic                     pop2_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [15:0]              head_o,
    output logic [15:0]              head1_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_n;

    always_comb begin
        pop_n = '0;
        if (pop2_i) begin
            pop_n = CW'(2);
        end else if (pop1_i) begin
            pop_n = CW'(1);
        end
        rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        count_d  = count_q + CW'(push_i) - pop_n;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem reads into a prefetch FIFO, one decoded instruction per cycle.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [15:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        branchTaken_i,
    input  logic [15:0] branchTarget_i,
    output logic        valid_o,
    output logic [15:0] pc_o,
    output logic [1:0]  format_o,
    output logic [3:0]  opcode_o,
    output logic [2:0]  regD_o,
    output logic [2:0]  reg1_o,
    output logic [2:0]  reg2_o,
    output logic [2:0]  imm_o,
    output logic        immFlag_o,
    output logic [15:0] jmpLoc_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q;
    logic [15:0]  fetch_pc_q, issue_pc_q, addr_q, pc_q, jmp_q;
    logic         req_q, valid_q;
    insn_fields_t fields_q, head_f;

    logic [CW-1:0] count;
    logic [15:0]   head, head1;
    logic          push, pop1, pop2, head_is_jump;

    assign head_f       = split_word(head);
    assign head_is_jump = (head_f.format == FMT_JUMP);
    assign push = (state_q == WAIT) && imem_valid_i && !branchTaken_i;
    assign pop1 = !branchTaken_i && !stall_i && !head_is_jump && (count >= CW'(1));
    assign pop2 = !branchTaken_i && !stall_i &&  head_is_jump && (count >= CW'(2));

    if_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (branchTaken_i),
        .push_i  (push),
        .data_i  (imem_rdata_i),
        .pop1_i  (pop1),
        .pop2_i  (pop2),
        .count_o (count),
        .head_o  (head),
        .head1_o (head1)
    );

    // A redirect that coincides with the response consumes it, so no DISCARD is needed then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            req_q <= 1'b0;
            if (branchTaken_i) begin
                fetch_pc_q <= branchTarget_i;
                state_q    <= (state_q != IDLE && !imem_valid_i) ? DISCARD : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (count < CW'(FIFO_DEPTH)) begin
                            req_q      <= 1'b1;
                            addr_q     <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 16'd1;
                            state_q    <= WAIT;
                        end
                    end
                    WAIT, DISCARD: begin
                        if (imem_valid_i) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            fields_q   <= '0;
            jmp_q      <= '0;
            issue_pc_q <= RESET_PC;
        end else if (branchTaken_i) begin
            valid_q    <= 1'b0;
            issue_pc_q <= branchTarget_i;
        end else if (!stall_i) begin
            if (pop1) begin
                valid_q    <= 1'b1;
                pc_q       <= issue_pc_q;
                fields_q   <= head_f;
                jmp_q      <= '0;
                issue_pc_q <= issue_pc_q + 16'd1;
            end else if (pop2) begin
                valid_q    <= 1'b1;
                pc_q       <= issue_pc_q;
                fields_q   <= head_f;
                jmp_q      <= head1;
                issue_pc_q <= issue_pc_q + 16'd2;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign format_o    = fields_q.format;
    assign opcode_o    = fields_q.opcode;
    assign regD_o      = fields_q.reg_d;
    assign reg1_o      = fields_q.reg1;
    assign reg2_o      = fields_q.reg2;
    assign imm_o       = fields_q.reg2;
    assign immFlag_o   = fields_q.imm_flag;
    assign jmpLoc_o    = jmp_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural imem with programmable latency and a scoreboard of expected issues.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_valid_i = 1'b0;
    logic [15:0] imem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        branchTaken_i = 1'b0;
    logic [15:0] branchTarget_i = '0;
    logic        valid_o;
    logic [15:0] pc_o;
    logic [1:0]  format_o;
    logic [3:0]  opcode_o;
    logic [2:0]  regD_o, reg1_o, reg2_o, imm_o;
    logic        immFlag_o;
    logic [15:0] jmpLoc_o;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_valid_i   (imem_valid_i),
        .imem_rdata_i   (imem_rdata_i),
        .stall_i        (stall_i),
        .branchTaken_i  (branchTaken_i),
        .branchTarget_i (branchTarget_i),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .format_o       (format_o),
        .opcode_o       (opcode_o),
        .regD_o         (regD_o),
        .reg1_o         (reg1_o),
        .reg2_o         (reg2_o),
        .imm_o          (imm_o),
        .immFlag_o      (immFlag_o),
        .jmpLoc_o       (jmpLoc_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
        logic [15:0] jmp;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_issue(input logic [15:0] pc, input logic [15:0] word, input logic [15:0] jmp);
        exp_t e;
        e.pc = pc; e.word = word; e.jmp = jmp;
        exp_q.push_back(e);
    endtask

    // Instruction memory: one request at a time, response after lat cycles.
    logic [15:0] mem [0:65535];
    int          lat = 1;
    bit          pend = 0;
    logic [15:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          req_cnt = 0;
    int          resp_cnt = 0;
    logic [15:0] req_log[$];

    always @(negedge clk) begin
        imem_valid_i = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_valid_i = 1'b1;
                    imem_rdata_i = mem[pend_addr];
                    pend = 0;
                    resp_cnt++;
                end
            end
            if (imem_req_o) begin
                req_cnt++;
                req_log.push_back(imem_addr_o);
                pend = 1;
                pend_addr = imem_addr_o;
                pend_cnt = lat;
            end
        end
    end

    bit mon_en = 0;
    bit mon_adv;
    exp_t mon_e;

    always @(posedge clk) begin
        mon_adv = rst_n && !stall_i && !branchTaken_i;
        #1;
        if (mon_en && mon_adv && valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {31'b0, valid_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_pc", pc_o, mon_e.pc);
                chk("issue_fields", {format_o, opcode_o, regD_o, reg1_o, reg2_o, immFlag_o}, mon_e.word);
                chk("issue_imm", imm_o, mon_e.word[3:1]);
                chk("issue_jmp", jmpLoc_o, mon_e.jmp);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        mon_en = 0;
        stall_i = 1'b0;
        branchTaken_i = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 16'h0000);
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_jmp", jmpLoc_o, 0);
        repeat (2) @(negedge clk);
        req_cnt = 0;
        resp_cnt = 0;
        req_log.delete();
    endtask

    task automatic release_dut();
        mon_en = 1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, exp_q.size(), 0);
        mon_en = 0;
    endtask

    task automatic wait_req_log(input int n, input int budget, input string tag);
        int i;
        for (i = 0; i < budget && req_log.size() < n; i++) @(negedge clk);
        chk(tag, (req_log.size() >= n), 1);
    endtask

    initial begin
        int cyc;
        int bad;
        int early;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // Straight-line code then a two-word jump.
        lat = 1;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'(i);
            expect_issue(16'(i), 16'(i), 16'h0);
        end
        mem[4] = 16'h1111; mem[5] = 16'hC000; mem[6] = 16'h1234; mem[7] = 16'h2222;
        expect_issue(16'h4, 16'h1111, 16'h0);
        expect_issue(16'h5, 16'hC000, 16'h1234);
        expect_issue(16'h7, 16'h2222, 16'h0);
        release_dut();
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (valid_o) begin cyc = i; break; end
        end
        chk("first_valid_lat", (cyc >= 3 && cyc <= 4), 1);
        wait_drain(80, "drain_basic");

        // Jump split across slow fetches.
        lat = 4;
        reset_dut();
        mem[0] = 16'hC0AB; mem[1] = 16'hABCD; mem[2] = 16'h0005;
        expect_issue(16'h0, 16'hC0AB, 16'hABCD);
        expect_issue(16'h2, 16'h0005, 16'h0);
        release_dut();
        early = 0;
        for (int i = 0; i < 60 && exp_q.size() == 2; i++) begin
            @(negedge clk);
            if (valid_o && resp_cnt < 2) early++;
        end
        chk("jsplit_early", early, 0);
        wait_drain(60, "drain_jsplit");

        // Stall from reset: fetch fills the FIFO and stops.
        lat = 1;
        reset_dut();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
        stall_i = 1'b1;
        release_dut();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || pc_o !== 16'h0) bad++;
        end
        chk("stall_frozen_empty", bad, 0);
        chk("stall_req_count", req_cnt, 4);
        for (int i = 0; i < 8; i++) expect_issue(16'(i), 16'h0100 + 16'(i), 16'h0);
        stall_i = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() == 8; i++) @(negedge clk);
        stall_i = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || pc_o !== 16'h0 || {format_o, opcode_o, regD_o, reg1_o, reg2_o, immFlag_o} !== 16'h0100) bad++;
        end
        chk("stall_frozen_valid", bad, 0);
        stall_i = 1'b0;
        wait_drain(80, "drain_stall");

        // Redirect while a slow response is outstanding.
        lat = 4;
        reset_dut();
        mem[0] = 16'h0011;
        for (int i = 0; i < 4; i++) begin
            mem[16'h40 + i] = 16'h0140 + 16'(i);
            expect_issue(16'h40 + 16'(i), 16'h0140 + 16'(i), 16'h0);
        end
        release_dut();
        for (int i = 0; i < 10 && !imem_req_o; i++) @(negedge clk);
        branchTaken_i = 1'b1;
        branchTarget_i = 16'h0040;
        @(negedge clk);
        branchTaken_i = 1'b0;
        wait_req_log(2, 30, "redir_req_seen");
        if (req_log.size() >= 2) chk("redir_req_addr", req_log[1], 16'h0040);
        wait_drain(80, "drain_redir");

        // Redirect coinciding with a response under stall, target near the top of memory.
        lat = 1;
        reset_dut();
        mem[16'hFFFE] = 16'h0101; mem[16'hFFFF] = 16'h0202;
        mem[0] = 16'h0303; mem[1] = 16'h0404;
        expect_issue(16'hFFFE, 16'h0101, 16'h0);
        expect_issue(16'hFFFF, 16'h0202, 16'h0);
        expect_issue(16'h0000, 16'h0303, 16'h0);
        expect_issue(16'h0001, 16'h0404, 16'h0);
        stall_i = 1'b1;
        release_dut();
        for (int i = 0; i < 10 && !imem_req_o; i++) @(negedge clk);
        @(negedge clk);
        branchTaken_i = 1'b1;
        branchTarget_i = 16'hFFFE;
        #1;
        chk("redir_coincident_resp", imem_valid_i, 1);
        @(negedge clk);
        branchTaken_i = 1'b0;
        stall_i = 1'b0;
        wait_req_log(4, 40, "wrap_reqs_seen");
        if (req_log.size() >= 4) begin
            chk("wrap_req1", req_log[1], 16'hFFFE);
            chk("wrap_req3", req_log[3], 16'h0000);
        end
        wait_drain(80, "drain_wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
